// File: rtl/vnlp_list_writer.sv
// Streams vector elements into VNLP memory as a linked list: elements, then length, then next-pointer.
// Optional bounds/overflow checking with sticky err is enabled by defining VNLP_WRITER_BOUNDS_EN.
module vnlp_list_writer #(
   parameter int unsigned word_size = 24,
   parameter int unsigned len_size  = 8,
   parameter int unsigned addr_bits = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [addr_bits-1:0] base_addr,
   input  logic [len_size-1:0]  num_vecs,
   input  logic                 in_valid,
   input  logic [word_size-1:0] in_data,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic [addr_bits-1:0] wr_addr,
   output logic [word_size-1:0] wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_LEN,
      S_NEXT,
      S_DONE
   } state_t;

   state_t               state;
   logic [addr_bits-1:0] node;
   logic [len_size-1:0]  cnt;
   logic [len_size-1:0]  vec;
   logic [len_size-1:0]  nvecs;
   logic [addr_bits-1:0] elem_addr;
   logic [len_size-1:0]  vec_nx;

   // node+2+cnt is both the next element slot in DATA and the next node address in NEXT
   assign elem_addr = node + addr_bits'(cnt) + addr_bits'(2);
   assign vec_nx    = vec + 1'b1;

   assign in_ready = (state == S_DATA);
   assign busy     = (state != S_IDLE);

`ifdef VNLP_WRITER_BOUNDS_EN
   localparam int unsigned xw = ((addr_bits > len_size) ? addr_bits : len_size) + 2;
   localparam logic [xw-1:0] addr_max = xw'((64'd1 << addr_bits) - 64'd1);

   logic [xw-1:0] elem_addr_x;
   logic          elem_ovf;
   logic          cnt_full;
   logic          hdr_ovf;
   logic          err_q;

   assign elem_addr_x = xw'(node) + xw'(cnt) + xw'(2);
   assign elem_ovf    = (elem_addr_x > addr_max);
   assign cnt_full    = (cnt == '1);
   assign hdr_ovf     = (node == '1);
   assign err         = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         node    <= '0;
         cnt     <= '0;
         vec     <= '0;
         nvecs   <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         done    <= 1'b0;
`ifdef VNLP_WRITER_BOUNDS_EN
         err_q   <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
`ifdef VNLP_WRITER_BOUNDS_EN
                  err_q <= 1'b0;
`endif
                  node  <= base_addr;
                  cnt   <= '0;
                  vec   <= '0;
                  nvecs <= num_vecs;
                  if (num_vecs == '0) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (in_valid) begin
`ifdef VNLP_WRITER_BOUNDS_EN
                  if (elem_ovf || (cnt_full && !in_last)) begin
                     err_q <= 1'b1;
                     state <= S_IDLE;
                  end else
`endif
                  begin
                     wr_en   <= 1'b1;
                     wr_addr <= elem_addr;
                     wr_data <= in_data;
                     cnt     <= cnt + 1'b1;
                     if (in_last) begin
                        state <= S_LEN;
                     end
                  end
               end
            end

            S_LEN: begin
`ifdef VNLP_WRITER_BOUNDS_EN
               if (hdr_ovf) begin
                  err_q <= 1'b1;
                  state <= S_IDLE;
               end else
`endif
               begin
                  wr_en   <= 1'b1;
                  wr_addr <= node + addr_bits'(1);
                  wr_data <= word_size'(cnt);
                  state   <= S_NEXT;
               end
            end

            S_NEXT: begin
               vec <= vec_nx;
               if (vec_nx == nvecs) begin
                  wr_en   <= 1'b1;
                  wr_addr <= node;
                  wr_data <= '0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
`ifdef VNLP_WRITER_BOUNDS_EN
                  if (elem_ovf) begin
                     err_q <= 1'b1;
                     state <= S_IDLE;
                  end else
`endif
                  begin
                     wr_en   <= 1'b1;
                     wr_addr <= node;
                     wr_data <= word_size'(elem_addr);
                     node    <= elem_addr;
                     cnt     <= '0;
                     state   <= S_DATA;
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
